control_unit: RTL and testbench

Microsequencer that drives the 8-bit edulent `data_path`. It fetches each opcode through the datapath's MA/MD/IR transfers, decodes the opcode and issues the per-cycle transfer, PC, SP and ALU strobes that execute it. It sits beside `data_path` in the CPU top level and is the only source of that block's control inputs.

---
 rtl/edulent_pkg.sv | 93 +++++++++
 rtl/control_unit_if.sv | 28 ++
 rtl/cu_microcode.sv | 83 ++++++++
 rtl/control_unit.sv | 160 ++++++++++++++++
 tb/tb_control_unit.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/edulent_pkg.sv
// Shared types for the edulent control unit: transfer codes, FSM states,
// opcode constants, opcode classes and the micro-op word.
// Ports: none (package); imported by cu_microcode and control_unit.
package edulent_pkg;

  // Datapath transfer codes (value on o_transfer_cmd).
  typedef enum logic [3:0] {
    XFER_NONE    = 4'h0,
    XFER_MA_PC   = 4'h1,
    XFER_MD_MEM  = 4'h2,
    XFER_IR_MD   = 4'h3,
    XFER_MA_MD   = 4'h4,
    XFER_REG_MD  = 4'h5,
    XFER_MA_AP   = 4'h6,
    XFER_MA_SP   = 4'h7,
    XFER_MD_REG  = 4'h8,
    XFER_MEM_MD  = 4'h9,
    XFER_REG_ALU = 4'hA,
    XFER_JUMP    = 4'hB,
    XFER_OP_C0   = 4'hC,
    XFER_OP_D0   = 4'hD,
    XFER_OP_E0   = 4'hE,
    XFER_MD_PC   = 4'hF
  } xfer_cmd_e;

  typedef enum logic [3:0] {
    IDLE, F_MA, F_WAIT, F_MD, F_IR, DECODE, EXEC, HALT, TRAP
  } cu_state_e;

  // Opcode classes; each class shares one execute sequence.
  typedef enum logic [3:0] {
    CLS_NOP, CLS_LDI, CLS_LDD, CLS_LDX, CLS_POP, CLS_STD, CLS_PUSH, CLS_PUSHPC,
    CLS_ALUI, CLS_ALUU, CLS_JMP, CLS_C0, CLS_D0, CLS_E0, CLS_HALT, CLS_ILL
  } op_class_e;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_POP  = 8'hC1;
  localparam logic [7:0] OP_PSPC = 8'hF0;
  localparam logic [7:0] OP_C0   = 8'hC0;
  localparam logic [7:0] OP_D0   = 8'hD0;
  localparam logic [7:0] OP_E0   = 8'hE0;
  localparam logic [7:0] OP_HALT = 8'hFF;

  localparam logic [1:0] SP_HOLD = 2'b00;
  localparam logic [1:0] SP_INC  = 2'b01;
  localparam logic [1:0] SP_DEC  = 2'b10;

  // One micro-op; wt marks a memory-latency idle slot lasting RD_WAIT cycles.
  typedef struct packed {
    xfer_cmd_e  cmd;
    logic       inc_pc;
    logic [1:0] sp;
    logic       alu_calc;
    logic       res_to_ap;
    logic       wt;
  } cu_uop_t;

  localparam cu_uop_t UOP_IDLE = '{cmd: XFER_NONE, inc_pc: 1'b0, sp: SP_HOLD,
                                   alu_calc: 1'b0, res_to_ap: 1'b0, wt: 1'b0};
  localparam cu_uop_t UOP_WAIT = '{cmd: XFER_NONE, inc_pc: 1'b0, sp: SP_HOLD,
                                   alu_calc: 1'b0, res_to_ap: 1'b0, wt: 1'b1};

  function automatic cu_uop_t mk_uop(xfer_cmd_e c, logic pc, logic [1:0] s,
                                     logic alu, logic ap);
    mk_uop = '{cmd: c, inc_pc: pc, sp: s, alu_calc: alu, res_to_ap: ap, wt: 1'b0};
  endfunction

  function automatic cu_uop_t xfer_only(xfer_cmd_e c);
    xfer_only = mk_uop(c, 1'b0, SP_HOLD, 1'b0, 1'b0);
  endfunction

  function automatic op_class_e op_class(logic [7:0] op);
    casez (op)
      OP_NOP:                                 op_class = CLS_NOP;
      8'h11, 8'h13:                           op_class = CLS_LDI;
      8'h19, 8'h1B:                           op_class = CLS_LDD;
      8'h14, 8'h1E:                           op_class = CLS_LDX;
      OP_POP:                                 op_class = CLS_POP;
      8'h21, 8'h23:                           op_class = CLS_STD;
      8'h2C, 8'h2E:                           op_class = CLS_PUSH;
      OP_PSPC:                                op_class = CLS_PUSHPC;
      8'h3?, 8'h4?, 8'h6?, 8'h7?, 8'h8?:      op_class = CLS_ALUI;
      8'h5?, 8'h9?:                           op_class = CLS_ALUU;
      8'hA1, 8'hA5, 8'hA9, 8'hB0:             op_class = CLS_JMP;
      OP_C0:                                  op_class = CLS_C0;
      OP_D0:                                  op_class = CLS_D0;
      OP_E0:                                  op_class = CLS_E0;
      OP_HALT:                                op_class = CLS_HALT;
      default:                                op_class = CLS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the control unit and the edulent datapath.
// Ports: i_run/i_ir into the sequencer; transfer code, PC/SP/ALU strobes,
// IR clear, fetch pulse and status flags out of it.
interface control_unit_if;
  logic       i_run;
  logic [7:0] i_ir;
  logic [3:0] o_transfer_cmd;
  logic       o_inc_pc;
  logic [1:0] o_inc_dec_sp;
  logic       o_alu_calculate;
  logic       o_alu_res_to_ap;
  logic       o_reset_ir;
  logic       o_next_instr;
  logic       o_halted;
  logic       o_illegal;

  modport master (
    input  i_run, i_ir,
    output o_transfer_cmd, o_inc_pc, o_inc_dec_sp, o_alu_calculate,
           o_alu_res_to_ap, o_reset_ir, o_next_instr, o_halted, o_illegal
  );

  modport slave (
    output i_run, i_ir,
    input  o_transfer_cmd, o_inc_pc, o_inc_dec_sp, o_alu_calculate,
           o_alu_res_to_ap, o_reset_ir, o_next_instr, o_halted, o_illegal
  );
endinterface

// File: rtl/cu_microcode.sv
// Opcode tables: maps (latched opcode, execute step) to one micro-op.
// Latency: purely combinational. Backpressure: none; the FSM holds step.
// Ports: op_q, step in; uop_out (micro-op word) and last (final step) out.
module cu_microcode
  import edulent_pkg::*;
#(
  parameter int RD_WAIT = 1
) (
  input  logic [7:0] op_q,
  input  logic [2:0] step,
  output cu_uop_t    uop_out,
  output logic       last
);

  cu_uop_t    seq [8];
  logic [3:0] len;
  op_class_e  cls;
  logic       ap;

  // The sequence is built as an ordered list so memory idle slots simply
  // vanish when RD_WAIT is 0; a wait slot is one list entry regardless of
  // RD_WAIT, which keeps the longest list (load direct) within 3 step bits.
  always_comb begin
    cls = op_class(op_q);
    ap  = ((op_q[7:4] == 4'h3) || (op_q[7:4] == 4'h4)) && op_q[0];
    seq = '{default: UOP_IDLE};
    len = 4'd0;

    // Operand fetch: MA<=PC, memory latency, MD<=mem with PC increment.
    if (cls inside {CLS_LDI, CLS_LDD, CLS_STD, CLS_ALUI, CLS_JMP}) begin
      seq[len[2:0]] = xfer_only(XFER_MA_PC); len = len + 4'd1;
      if (RD_WAIT > 0) begin seq[len[2:0]] = UOP_WAIT; len = len + 4'd1; end
      seq[len[2:0]] = mk_uop(XFER_MD_MEM, 1'b1, SP_HOLD, 1'b0, 1'b0); len = len + 4'd1;
    end

    case (cls)
      CLS_LDI: begin
        seq[len[2:0]] = xfer_only(XFER_REG_MD); len = len + 4'd1;
      end
      CLS_LDD, CLS_LDX, CLS_POP: begin
        if (cls == CLS_POP) begin
          // SP is pre-incremented in its own cycle so MA sees the new value.
          seq[len[2:0]] = mk_uop(XFER_NONE, 1'b0, SP_INC, 1'b0, 1'b0); len = len + 4'd1;
          seq[len[2:0]] = xfer_only(XFER_MA_SP); len = len + 4'd1;
        end else if (cls == CLS_LDD) begin
          seq[len[2:0]] = xfer_only(XFER_MA_MD); len = len + 4'd1;
        end else begin
          seq[len[2:0]] = xfer_only(XFER_MA_AP); len = len + 4'd1;
        end
        if (RD_WAIT > 0) begin seq[len[2:0]] = UOP_WAIT; len = len + 4'd1; end
        seq[len[2:0]] = xfer_only(XFER_MD_MEM); len = len + 4'd1;
        seq[len[2:0]] = xfer_only(XFER_REG_MD); len = len + 4'd1;
      end
      CLS_STD: begin
        seq[len[2:0]] = xfer_only(XFER_MA_MD);  len = len + 4'd1;
        seq[len[2:0]] = xfer_only(XFER_MD_REG); len = len + 4'd1;
        seq[len[2:0]] = xfer_only(XFER_MEM_MD); len = len + 4'd1;
      end
      CLS_PUSH, CLS_PUSHPC: begin
        seq[len[2:0]] = xfer_only(XFER_MA_SP); len = len + 4'd1;
        seq[len[2:0]] = xfer_only((cls == CLS_PUSH) ? XFER_MD_REG : XFER_MD_PC);
        len = len + 4'd1;
        seq[len[2:0]] = mk_uop(XFER_MEM_MD, 1'b0, SP_DEC, 1'b0, 1'b0); len = len + 4'd1;
      end
      CLS_ALUI, CLS_ALUU: begin
        // ap is only ever set for 3x/4x, which are immediate-class opcodes.
        seq[len[2:0]] = mk_uop(XFER_NONE, 1'b0, SP_HOLD, 1'b1, ap); len = len + 4'd1;
        seq[len[2:0]] = mk_uop(XFER_REG_ALU, 1'b0, SP_HOLD, 1'b0, ap); len = len + 4'd1;
      end
      CLS_JMP: begin
        seq[len[2:0]] = xfer_only(XFER_JUMP); len = len + 4'd1;
      end
      CLS_C0: begin seq[len[2:0]] = xfer_only(XFER_OP_C0); len = len + 4'd1; end
      CLS_D0: begin seq[len[2:0]] = xfer_only(XFER_OP_D0); len = len + 4'd1; end
      CLS_E0: begin seq[len[2:0]] = xfer_only(XFER_OP_E0); len = len + 4'd1; end
      default: ;
    endcase

    uop_out = seq[step];
    last    = ({1'b0, step} == (len - 4'd1));
  end

endmodule

// File: rtl/control_unit.sv
// Microsequencer for the edulent datapath: fetch, decode, execute strobes.
// Latency: fetch RD_WAIT+4 cycles to DECODE; outputs decode registered state only.
// Backpressure: i_run is honoured only at instruction boundaries; HALT/TRAP need reset.
// Ports: i_clk, i_rstn (async active-low), bus (control_unit_if.master).
// Build option: CU_ILLEGAL_TRAP_EN sends unlisted opcodes to TRAP; otherwise
// they run as NOP and o_illegal is tied low.
module control_unit
  import edulent_pkg::*;
#(
  parameter int RD_WAIT = 1  // memory read latency in idle cycles, 0..3
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  control_unit_if.master bus
);

  localparam logic [1:0] WAIT_LAST = 2'(RD_WAIT - 1);

  cu_state_e  state_q, state_d, boundary;
  logic [2:0] step_q, step_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic [7:0] op_q, op_d;
  op_class_e  dec_cls;
  cu_uop_t    uc;
  logic       uc_last;

  xfer_cmd_e  cmd;
  logic       inc_pc, alu_calc, res_to_ap, reset_ir, next_instr, halted;
  logic [1:0] sp;
`ifdef CU_ILLEGAL_TRAP_EN
  logic       trap;
`endif

  cu_microcode #(.RD_WAIT(RD_WAIT)) u_microcode (
    .op_q    (op_q),
    .step    (step_q),
    .uop_out (uc),
    .last    (uc_last)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      step_q  <= '0;
      wcnt_q  <= '0;
      op_q    <= OP_NOP;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      wcnt_q  <= wcnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    wcnt_d     = wcnt_q;
    op_d       = op_q;
    cmd        = XFER_NONE;
    inc_pc     = 1'b0;
    sp         = SP_HOLD;
    alu_calc   = 1'b0;
    res_to_ap  = 1'b0;
    reset_ir   = 1'b0;
    next_instr = 1'b0;
    halted     = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
    trap       = 1'b0;
`endif
    boundary   = bus.i_run ? F_MA : IDLE;
    // i_ir only steers the next state out of DECODE, never an output.
    dec_cls    = op_class(bus.i_ir);

    case (state_q)
      IDLE: if (bus.i_run) state_d = F_MA;
      F_MA: begin
        cmd        = XFER_MA_PC;
        reset_ir   = 1'b1;
        next_instr = 1'b1;
        wcnt_d     = '0;
        state_d    = (RD_WAIT == 0) ? F_MD : F_WAIT;
      end
      F_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          wcnt_d  = '0;
          state_d = F_MD;
        end else begin
          wcnt_d  = wcnt_q + 2'd1;
        end
      end
      F_MD: begin
        cmd     = XFER_MD_MEM;
        inc_pc  = 1'b1;
        state_d = F_IR;
      end
      F_IR: begin
        cmd     = XFER_IR_MD;
        state_d = DECODE;
      end
      DECODE: begin
        op_d   = bus.i_ir;
        step_d = '0;
        wcnt_d = '0;
        case (dec_cls)
          CLS_NOP:  state_d = boundary;
          CLS_HALT: state_d = HALT;
`ifdef CU_ILLEGAL_TRAP_EN
          CLS_ILL:  state_d = TRAP;
`else
          CLS_ILL:  state_d = boundary;
`endif
          default:  state_d = EXEC;
        endcase
      end
      EXEC: begin
        cmd       = uc.cmd;
        inc_pc    = uc.inc_pc;
        sp        = uc.sp;
        alu_calc  = uc.alu_calc;
        res_to_ap = uc.res_to_ap;
        // A wait slot stalls the step counter for RD_WAIT cycles.
        if (uc.wt && (wcnt_q != WAIT_LAST)) begin
          wcnt_d = wcnt_q + 2'd1;
        end else begin
          wcnt_d = '0;
          if (uc_last) begin
            step_d  = '0;
            state_d = boundary;
          end else begin
            step_d  = step_q + 3'd1;
          end
        end
      end
      HALT: halted = 1'b1;
      TRAP: begin
        halted = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
        trap   = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_transfer_cmd  = cmd;
  assign bus.o_inc_pc        = inc_pc;
  assign bus.o_inc_dec_sp    = sp;
  assign bus.o_alu_calculate = alu_calc;
  assign bus.o_alu_res_to_ap = res_to_ap;
  assign bus.o_reset_ir      = reset_ir;
  assign bus.o_next_instr    = next_instr;
  assign bus.o_halted        = halted;
`ifdef CU_ILLEGAL_TRAP_EN
  assign bus.o_illegal       = trap;
`else
  assign bus.o_illegal       = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit (RD_WAIT=1): a per-cycle expected
// strobe trace is generated from the opcode sequences and compared every cycle.
`timescale 1ns/1ps
module tb_control_unit;

  localparam int RD_WAIT = 1;
`ifdef CU_ILLEGAL_TRAP_EN
  localparam bit TRAP_BUILD = 1'b1;
`else
  localparam bit TRAP_BUILD = 1'b0;
`endif

  localparam int K_NOP = 0, K_LDI = 1, K_LDD = 2, K_LDX = 3, K_POP = 4, K_STD = 5;
  localparam int K_PUSH = 6, K_PUSHPC = 7, K_ALUI = 8, K_ALUU = 9, K_JMP = 10;
  localparam int K_C0 = 11, K_D0 = 12, K_E0 = 13, K_HALT = 14, K_ILL = 15;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  control_unit_if bus();

  control_unit #(.RD_WAIT(RD_WAIT)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected per-cycle trace: output word, i_ir to drive, i_run to drive.
  logic [12:0] exp_q [$];
  logic [7:0]  ir_q  [$];
  bit          run_q [$];
  bit          run_cur;

  logic [7:0] pool [$] = '{8'h00, 8'h11, 8'h13, 8'h19, 8'h1B, 8'h14, 8'h1E, 8'hC1,
                           8'h21, 8'h23, 8'h2C, 8'h2E, 8'hF0, 8'h30, 8'h31, 8'h40,
                           8'h41, 8'h67, 8'h7A, 8'h8C, 8'h55, 8'h9E, 8'hA1, 8'hA5,
                           8'hA9, 8'hB0, 8'hC0, 8'hD0, 8'hE0};

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [12:0] obs();
    return {bus.o_transfer_cmd, bus.o_inc_pc, bus.o_inc_dec_sp, bus.o_alu_calculate,
            bus.o_alu_res_to_ap, bus.o_reset_ir, bus.o_next_instr, bus.o_halted,
            bus.o_illegal};
  endfunction

  function automatic logic [12:0] w(int cmd, bit pc = 0, bit [1:0] sp = 0, bit alu = 0,
                                    bit ap = 0, bit rir = 0, bit ni = 0, bit hl = 0,
                                    bit il = 0);
    return {cmd[3:0], pc, sp, alu, ap, rir, ni, hl, il};
  endfunction

  function automatic void add(logic [12:0] word);
    exp_q.push_back(word);
    ir_q.push_back(8'($urandom));
    run_q.push_back(run_cur);
  endfunction

  function automatic void opi();
    add(w(1));
    repeat (RD_WAIT) add(w(0));
    add(w(2, 1));
  endfunction

  function automatic void rd();
    repeat (RD_WAIT) add(w(0));
    add(w(2));
  endfunction

  function automatic int op_kind(logic [7:0] op);
    casez (op)
      8'h00:                              return K_NOP;
      8'h11, 8'h13:                       return K_LDI;
      8'h19, 8'h1B:                       return K_LDD;
      8'h14, 8'h1E:                       return K_LDX;
      8'hC1:                              return K_POP;
      8'h21, 8'h23:                       return K_STD;
      8'h2C, 8'h2E:                       return K_PUSH;
      8'hF0:                              return K_PUSHPC;
      8'h3?, 8'h4?, 8'h6?, 8'h7?, 8'h8?:  return K_ALUI;
      8'h5?, 8'h9?:                       return K_ALUU;
      8'hA1, 8'hA5, 8'hA9, 8'hB0:         return K_JMP;
      8'hC0:                              return K_C0;
      8'hD0:                              return K_D0;
      8'hE0:                              return K_E0;
      8'hFF:                              return K_HALT;
      default:                            return K_ILL;
    endcase
  endfunction

  // Appends the full expected trace of one instruction; returns its kind.
  function automatic int gen(logic [7:0] op);
    int k = op_kind(op);
    bit ap = ((op[7:4] == 4'h3) || (op[7:4] == 4'h4)) && op[0];
    add(w(1, 0, 0, 0, 0, 1, 1));
    repeat (RD_WAIT) add(w(0));
    add(w(2, 1));
    add(w(3));
    add(w(0));
    ir_q[ir_q.size() - 1] = op;
    case (k)
      K_LDI:    begin opi(); add(w(5)); end
      K_LDD:    begin opi(); add(w(4)); rd(); add(w(5)); end
      K_LDX:    begin add(w(6)); rd(); add(w(5)); end
      K_POP:    begin add(w(0, 0, 2'b01)); add(w(7)); rd(); add(w(5)); end
      K_STD:    begin opi(); add(w(4)); add(w(8)); add(w(9)); end
      K_PUSH:   begin add(w(7)); add(w(8)); add(w(9, 0, 2'b10)); end
      K_PUSHPC: begin add(w(7)); add(w(15)); add(w(9, 0, 2'b10)); end
      K_ALUI:   begin opi(); add(w(0, 0, 0, 1, ap)); add(w(10, 0, 0, 0, ap)); end
      K_ALUU:   begin add(w(0, 0, 0, 1)); add(w(10)); end
      K_JMP:    begin opi(); add(w(11)); end
      K_C0:     add(w(12));
      K_D0:     add(w(13));
      K_E0:     add(w(14));
      default:  ;
    endcase
    return k;
  endfunction

  function automatic logic [7:0] pick_op();
    logic [7:0] op;
    if ($urandom_range(0, 3) == 0) begin
      op = 8'($urandom);
      while (op == 8'hFF || (TRAP_BUILD && op_kind(op) == K_ILL)) op = 8'($urandom);
    end else begin
      op = pool[$urandom_range(0, pool.size() - 1)];
    end
    return op;
  endfunction

  // Plays up to n queued cycles: drive inputs, check outputs at the falling edge.
  task automatic run_cycles(int n, string tag);
    logic [12:0] e;
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      bus.i_ir  = ir_q.pop_front();
      bus.i_run = run_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      check(tag, 32'(obs()), 32'(e));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(logic [7:0] op);
    int k;
    k = gen(op);
    run_cycles(exp_q.size(), $sformatf("op%02h_k%0d", op, k));
  endtask

  task automatic do_reset();
    exp_q.delete(); ir_q.delete(); run_q.delete();
    bus.i_run = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int k;
    logic [7:0] dir [$];
    rstn = 1'b0;
    bus.i_run = 1'b0;
    bus.i_ir = 8'h00;
    run_cur = 1'b0;
    #12;
    check("reset_outputs", 32'(obs()), 32'd0);
    do_reset();

    // Held in IDLE with i_run low: no fetch pulse.
    repeat (4) add(w(0));
    run_cycles(4, "idle_run_low");

    // IDLE cycle in which i_run rises, then directed programs.
    run_cur = 1'b1;
    add(w(0));
    run_cycles(1, "idle_run_rise");
    dir = '{8'h11, 8'h30, 8'h41, 8'h2C, 8'hA1, 8'hA5, 8'h19, 8'h1E, 8'hC1, 8'h23,
            8'hF0, 8'h55, 8'h9A, 8'hE0, 8'hC0, 8'hD0, 8'h00};
    if (!TRAP_BUILD) dir.push_back(8'h02);
    foreach (dir[i]) run_op(dir[i]);

    // Randomised instruction stream.
    for (int i = 0; i < 60; i++) run_op(pick_op());

    // i_run dropped mid-execute: instruction completes, then IDLE.
    base = exp_q.size();
    k = gen(8'h19);
    for (int i = base + 7; i < run_q.size(); i++) run_q[i] = 1'b0;
    run_cur = 1'b0;
    repeat (3) add(w(0));
    run_cur = 1'b1;
    add(w(0));
    run_cycles(exp_q.size(), $sformatf("run_drop_k%0d", k));
    run_op(8'h11);

    // Reset pulsed during execute of 19: outputs clear at once, IDLE after.
    k = gen(8'h19);
    run_cycles(RD_WAIT + 7, "pre_reset");
    #2 rstn = 1'b0;
    #1 check("reset_mid_exec", 32'(obs()), 32'd0);
    do_reset();
    run_cur = 1'b0;
    repeat (3) add(w(0));
    run_cur = 1'b1;
    add(w(0));
    run_cycles(exp_q.size(), "post_reset_idle");
    run_op(8'h13);

`ifdef CU_ILLEGAL_TRAP_EN
    // Unlisted opcode traps: sticky illegal + halted, no strobes.
    k = gen(8'h02);
    repeat (2) add(w(0, 0, 0, 0, 0, 0, 0, 1, 1));
    run_cur = 1'b0;
    repeat (3) add(w(0, 0, 0, 0, 0, 0, 0, 1, 1));
    run_cycles(exp_q.size(), $sformatf("trap_k%0d", k));
    rstn = 1'b0;
    #1 check("reset_from_trap", 32'(obs()), 32'd0);
    do_reset();
    run_cur = 1'b1;
    add(w(0));
    run_cycles(1, "trap_restart");
`endif

    // HALT: entered after FF decode, ignores i_run.
    run_cur = 1'b1;
    k = gen(8'hFF);
    repeat (3) add(w(0, 0, 0, 0, 0, 0, 0, 1));
    run_cur = 1'b0;
    repeat (3) add(w(0, 0, 0, 0, 0, 0, 0, 1));
    run_cycles(exp_q.size(), $sformatf("halt_k%0d", k));

    rstn = 1'b0;
    #1 check("reset_from_halt", 32'(obs()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
